// File: rtl/nibble_add_pkg.sv
// Shared types and the round-robin pick helper for the nibble adder arbiter.
package nibble_add_pkg;
  localparam int N_REQ_DEF = 4;
  localparam int W_DEF     = 4;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_e;

  typedef struct packed {
    logic       vld;
    logic [2:0] idx;
  } pick_t;

  // First set request at or after ptr, wrapping modulo n (n <= 8).
  // Iterating from the far end backwards leaves the nearest hit in p.
  function automatic pick_t rr_pick(input logic [7:0] req, input logic [2:0] ptr, input int n);
    pick_t p;
    int    k;
    p = '0;
    for (int i = 7; i >= 0; i--) begin
      if (i < n) begin
        k = (int'(ptr) + i) % n;
        if (req[k[2:0]]) begin
          p.vld = 1'b1;
          p.idx = k[2:0];
        end
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/nibble_add_arbiter_adder.sv
// Registered W-bit adder with load enable; output is {carry, sum}.
module nibble_adder #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic [W:0]   sum_o
);
  logic [W:0] sum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)       sum_q <= '0;
    else if (ld_i) sum_q <= {1'b0, a_i} + {1'b0, b_i};
  end

  assign sum_o = sum_q;
endmodule

// File: rtl/nibble_add_arbiter.sv
// Round-robin sharing of one registered nibble adder among N_REQ requesters,
// with a valid/ready result port.
module nibble_add_arbiter
  import nibble_add_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF,
  parameter int W     = W_DEF,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] a_flat,
  input  logic [N_REQ*W-1:0] b_flat,
  output logic [N_REQ-1:0]   gnt,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [W-1:0]       resp_sum,
  output logic               resp_carry,
  output logic [ID_W-1:0]    resp_id,
  output logic               busy
);
  state_e          state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [W:0]      add_q;
  pick_t           pick;
  logic [ID_W-1:0] win;

  always_comb pick = rr_pick(8'(req), 3'(ptr_q), N_REQ);
  assign win = ID_W'(pick.idx);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    a_d     = a_q;
    b_d     = b_q;
    unique case (state_q)
      IDLE: if (pick.vld) begin
        id_d    = win;
        a_d     = a_flat[win*W +: W];
        b_d     = b_flat[win*W +: W];
        ptr_d   = win + 1'b1;  // power-of-two N_REQ: natural wrap
        state_d = CALC;
      end
      CALC: state_d = RESP;
      RESP: if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      a_q     <= a_d;
      b_q     <= b_d;
    end
  end

  nibble_adder #(.W(W)) u_add (
    .clk   (clk),
    .rst   (reset),
    .ld_i  (state_q == CALC),
    .a_i   (a_q),
    .b_i   (b_q),
    .sum_o (add_q)
  );

  for (genvar g = 0; g < N_REQ; g++) begin : g_gnt
    assign gnt[g] = (state_q == CALC) && (id_q == ID_W'(g));
  end

  assign resp_valid = (state_q == RESP);
  assign resp_sum   = add_q[W-1:0];
  assign resp_carry = add_q[W];
  assign resp_id    = id_q;
  assign busy       = (state_q != IDLE);
endmodule
